// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single port of the unified instruction/data memory between the
// instruction-fetch (IF) stage and the data-memory (DM) stage.
//
// Each transaction runs through a fixed-latency IDLE -> ISSUE -> WAIT -> RESP
// sequence. DM wins when both stages request at once. A bounded-starvation
// counter forces an IF grant once DM has won STARVE_LIMIT consecutive
// contested arbitrations.
//
// Parameters
//   LATENCY      : edges from the mem_en edge until mem_rdata is valid (1..15)
//   STARVE_LIMIT : consecutive contested DM grants before IF is forced (1..15)
//
// Ports
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   if_req / if_addr        : IF read request, held until if_ack
//   if_ack / if_rdata       : one-cycle IF acknowledge with registered data
//   dm_req / dm_we          : DM request (dm_we=1 write), held until dm_ack
//   dm_addr / dm_wdata      : DM address and write data
//   dm_ack / dm_rdata       : one-cycle DM acknowledge with registered data
//   mem_en / mem_we         : one-cycle access strobe and write enable
//   mem_addr / mem_wdata    : address and write data latched at grant
//   mem_rdata               : memory read data
//   busy                    : high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int LATENCY      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [3:0] LAT_C    = 4'(LATENCY);
    localparam logic [3:0] STARVE_C = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Registered state and outputs
    state_t      state_r;
    logic        owner_dm_r;     // 1: current transaction belongs to DM
    logic [3:0]  starve_cnt_r;
    logic [3:0]  wait_cnt_r;
    logic        mem_en_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic        if_ack_r;
    logic        dm_ack_r;
    logic [31:0] if_rdata_r;
    logic [31:0] dm_rdata_r;
    logic        busy_r;

    // Next-state values
    state_t      state_next_s;
    logic        owner_dm_next_s;
    logic [3:0]  starve_next_s;
    logic [3:0]  wait_next_s;
    logic        mem_en_next_s;
    logic        mem_we_next_s;
    logic [31:0] mem_addr_next_s;
    logic [31:0] mem_wdata_next_s;
    logic        if_ack_next_s;
    logic        dm_ack_next_s;
    logic [31:0] if_rdata_next_s;
    logic [31:0] dm_rdata_next_s;
    logic        busy_next_s;

    // Arbitration
    logic        starve_hit_s;
    logic        dm_wins_s;

    // Winner selection: DM has priority unless IF has been starved to the limit.
    always_comb begin
        starve_hit_s = (starve_cnt_r == STARVE_C);
        dm_wins_s    = 1'b0;
        if (dm_req && !(if_req && starve_hit_s)) begin
            dm_wins_s = 1'b1;
        end else begin
            dm_wins_s = 1'b0;
        end
    end

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_next_s     = state_r;
        owner_dm_next_s  = owner_dm_r;
        starve_next_s    = starve_cnt_r;
        wait_next_s      = wait_cnt_r;
        mem_en_next_s    = 1'b0;
        mem_we_next_s    = mem_we_r;
        mem_addr_next_s  = mem_addr_r;
        mem_wdata_next_s = mem_wdata_r;
        if_ack_next_s    = 1'b0;
        dm_ack_next_s    = 1'b0;
        if_rdata_next_s  = if_rdata_r;
        dm_rdata_next_s  = dm_rdata_r;
        busy_next_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    state_next_s    = ST_ISSUE;
                    mem_en_next_s   = 1'b1;
                    owner_dm_next_s = dm_wins_s;
                    if (dm_wins_s) begin
                        mem_addr_next_s  = dm_addr;
                        mem_we_next_s    = dm_we;
                        mem_wdata_next_s = dm_wdata;
                        // Only a contested DM win counts against IF.
                        if (if_req && (starve_cnt_r < STARVE_C)) begin
                            starve_next_s = starve_cnt_r + 4'd1;
                        end else begin
                            starve_next_s = starve_cnt_r;
                        end
                    end else begin
                        mem_addr_next_s  = if_addr;
                        mem_we_next_s    = 1'b0;
                        mem_wdata_next_s = 32'd0;
                        starve_next_s    = 4'd0;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                wait_next_s  = LAT_C;
                state_next_s = ST_WAIT;
            end

            ST_WAIT: begin
                // A count of 0 cannot occur with a legal LATENCY; treating
                // it as done keeps the counter from wrapping.
                if (wait_cnt_r <= 4'd1) begin
                    wait_next_s  = 4'd0;
                    state_next_s = ST_RESP;
                    if (owner_dm_r) begin
                        dm_ack_next_s = 1'b1;
                        if (!mem_we_r) begin
                            dm_rdata_next_s = mem_rdata;
                        end else begin
                            dm_rdata_next_s = dm_rdata_r;
                        end
                    end else begin
                        if_ack_next_s   = 1'b1;
                        if_rdata_next_s = mem_rdata;
                    end
                end else begin
                    wait_next_s  = wait_cnt_r - 4'd1;
                    state_next_s = ST_WAIT;
                end
            end

            ST_RESP: begin
                state_next_s = ST_IDLE;
            end

            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        busy_next_s = (state_next_s != ST_IDLE);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            owner_dm_r   <= 1'b0;
            starve_cnt_r <= 4'd0;
            wait_cnt_r   <= 4'd0;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 32'd0;
            mem_wdata_r  <= 32'd0;
            if_ack_r     <= 1'b0;
            dm_ack_r     <= 1'b0;
            if_rdata_r   <= 32'd0;
            dm_rdata_r   <= 32'd0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            owner_dm_r   <= owner_dm_next_s;
            starve_cnt_r <= starve_next_s;
            wait_cnt_r   <= wait_next_s;
            mem_en_r     <= mem_en_next_s;
            mem_we_r     <= mem_we_next_s;
            mem_addr_r   <= mem_addr_next_s;
            mem_wdata_r  <= mem_wdata_next_s;
            if_ack_r     <= if_ack_next_s;
            dm_ack_r     <= dm_ack_next_s;
            if_rdata_r   <= if_rdata_next_s;
            dm_rdata_r   <= dm_rdata_next_s;
            busy_r       <= busy_next_s;
        end
    end

    assign if_ack    = if_ack_r;
    assign if_rdata  = if_rdata_r;
    assign dm_ack    = dm_ack_r;
    assign dm_rdata  = dm_rdata_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;

endmodule
